// File: rtl/iomem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iomem_pkg
//  Description : Shared types and constants for the picosoc iomem arbiter:
//                arbiter state encoding, default bus widths and the read
//                data returned to a master whose access timed out.
//  Revision    : 1.0 - initial release
// ============================================================================
package iomem_pkg;

    localparam int          IOMEM_ADDR_W        = 32;
    localparam int          IOMEM_DATA_W        = 32;
    localparam logic [31:0] IOMEM_TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } iomem_state_e;

endpackage : iomem_pkg
`default_nettype wire

// File: rtl/iomem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : iomem_arbiter_if
//  Description : One picosoc iomem bus link (valid/ready/wstrb/addr/wdata/
//                rdata).
//                  master modport : the side that issues requests
//                  slave  modport : the side that completes them
//                wstrb == 0 marks a read.
//  Revision    : 1.0 - initial release
// ============================================================================
interface iomem_arbiter_if
    import iomem_pkg::*;
#(
    parameter int ADDR_W = IOMEM_ADDR_W,
    parameter int DATA_W = IOMEM_DATA_W
);

    logic                  valid;
    logic                  ready;
    logic [DATA_W/8-1:0]   wstrb;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output valid, wstrb, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  valid, wstrb, addr, wdata,
        output ready, rdata
    );

endinterface : iomem_arbiter_if
`default_nettype wire

// File: rtl/iomem_arb_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : iomem_arb_timeout
//  Description : Bus watchdog counter for the iomem arbiter. It is used only
//                when IOMEM_ARB_TIMEOUT_EN is defined.
//                  clk, resetn : clock, synchronous active-low reset
//                  clear       : hold the count at zero (outside BUSY)
//                  enable      : count one BUSY cycle
//                  expired     : high in the TIMEOUT_CYCLES-th BUSY cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module iomem_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic clk,
    input  wire logic resetn,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);

    // The count holds the number of BUSY cycles already spent. The limit is
    // therefore reached in the cycle in which the count equals TIMEOUT_CYCLES-1.
    localparam logic [15:0] C_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            r_count <= 16'd0;
        end else if (enable && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign expired = enable && (r_count == C_LAST);

endmodule : iomem_arb_timeout
`default_nettype wire

// File: rtl/iomem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : iomem_arbiter
//  Description : Round-robin arbiter that shares the picosoc iomem peripheral
//                bus between two masters (m0 = PicoRV32, m1 = host bridge).
//                It runs one transaction at a time through the states
//                IDLE -> BUSY -> DONE.
//                  clk, resetn  : clock, synchronous active-low reset
//                  m0, m1       : master links (slave modport)
//                  s            : link to the decoded peripherals
//                  timeout_err  : one-cycle pulse when an access is aborted
//                  grant_id     : owner of the current or last grant
//                Optional feature: define IOMEM_ARB_TIMEOUT_EN to add a
//                bus-timeout watchdog (iomem_arb_timeout).
//  Revision    : 1.0 - initial release
// ============================================================================
module iomem_arbiter
    import iomem_pkg::*;
#(
    parameter int                ADDR_W         = IOMEM_ADDR_W,
    parameter int                DATA_W         = IOMEM_DATA_W,
    parameter int                TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = IOMEM_TIMEOUT_RDATA
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    iomem_arbiter_if.slave   m0,
    iomem_arbiter_if.slave   m1,
    iomem_arbiter_if.master  s,
    output logic             timeout_err,
    output logic             grant_id
);

    iomem_state_e      r_state;
    iomem_state_e      w_state_nxt;
    logic              r_grant_id;
    logic              w_grant_nxt;
    logic              r_rr_last;
    logic              w_rr_last_nxt;
    logic              w_gnt_valid;
    logic              w_done;
    logic              w_timeout;
    logic              w_complete;
    logic              w_expired;
    logic [DATA_W-1:0] w_rdata;

`ifdef IOMEM_ARB_TIMEOUT_EN
    iomem_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (r_state != BUSY),
        .enable  (r_state == BUSY),
        .expired (w_expired)
    );
`else
    // Without the watchdog, BUSY waits for the slave indefinitely.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{TIMEOUT_RDATA, 16'(TIMEOUT_CYCLES)};
    assign w_expired    = 1'b0;
`endif

    // The granted master drives the slave side directly. The mux follows the
    // registered grant, so the slave request path has no arbitration logic.
    assign w_gnt_valid = r_grant_id ? m1.valid : m0.valid;
    assign s.addr      = r_grant_id ? m1.addr  : m0.addr;
    assign s.wdata     = r_grant_id ? m1.wdata : m0.wdata;
    assign s.wstrb     = r_grant_id ? m1.wstrb : m0.wstrb;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_grant_id <= 1'b0;
            r_rr_last  <= 1'b1;   // m0 wins the first tie after reset
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_nxt;
            r_rr_last  <= w_rr_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant_id;
        w_rr_last_nxt = r_rr_last;
        s.valid       = 1'b0;
        w_done        = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            IDLE: begin
                if (m0.valid || m1.valid) begin
                    w_grant_nxt   = (m0.valid && m1.valid) ? ~r_rr_last : m1.valid;
                    w_rr_last_nxt = w_grant_nxt;
                    w_state_nxt   = BUSY;
                end
            end
            BUSY: begin
                s.valid = w_gnt_valid;
                if (!w_gnt_valid) begin
                    // The master withdrew its request. Abort without a ready
                    // pulse. The grant still counts for the round-robin.
                    w_state_nxt = IDLE;
                end else if (s.ready) begin
                    // A slave answer in the expiry cycle takes priority.
                    w_done      = 1'b1;
                    w_state_nxt = DONE;
                end else if (w_expired) begin
                    w_done      = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // A completion seen while reset is asserted is dropped. The access is
    // abandoned, so no master may see a ready for it.
    assign w_complete  = w_done & resetn;
    assign w_rdata     = w_timeout ? TIMEOUT_RDATA : s.rdata;

    assign m0.ready    = w_complete & ~r_grant_id;
    assign m1.ready    = w_complete &  r_grant_id;
    assign m0.rdata    = m0.ready ? w_rdata : '0;
    assign m1.rdata    = m1.ready ? w_rdata : '0;

    assign timeout_err = w_timeout & resetn;
    assign grant_id    = r_grant_id;

endmodule : iomem_arbiter
`default_nettype wire

// File: tb/tb_iomem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iomem_arbiter
//  Description : Directed self-checking bench for iomem_arbiter. It covers a
//                single write, round-robin fairness, read data pass-through,
//                a stray slave ready, reset during BUSY, master abort and the
//                watchdog (or its absence).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iomem_arbiter;
    import iomem_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic timeout_err;
    logic grant_id;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    iomem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    iomem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
    iomem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

    iomem_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_RDATA  (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .m0          (m0_if),
        .m1          (m1_if),
        .s           (s_if),
        .timeout_err (timeout_err),
        .grant_id    (grant_id)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Step to just after the next active edge; inputs are driven from here.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus;
        m0_if.valid = 1'b0; m0_if.wstrb = 4'h0; m0_if.addr = 32'h0; m0_if.wdata = 32'h0;
        m1_if.valid = 1'b0; m1_if.wstrb = 4'h0; m1_if.addr = 32'h0; m1_if.wdata = 32'h0;
        s_if.ready  = 1'b0; s_if.rdata  = 32'h0;
    endtask

    // Advance until s_valid is seen, for at most max_cyc cycles.
    task automatic wait_svalid(input int max_cyc, output int n);
        n = max_cyc;
        for (int k = 1; k <= max_cyc; k++) begin
            tick();
            s_if.ready = 1'b0;
            #2;
            if (s_if.valid) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "tb_iomem_arbiter watchdog expired");
    end

    initial begin
        int n;
        int served0;
        int served1;
        logic exp_g;
        logic saw;

        idle_bus();
        resetn = 1'b0;
        tick();
        tick();
        #2;
        check_value("rst_s_valid",  s_if.valid,  0);
        check_value("rst_m0_ready", m0_if.ready, 0);
        check_value("rst_m1_ready", m1_if.ready, 0);
        check_value("rst_tmo_err",  timeout_err, 0);
        check_value("rst_grant_id", grant_id,    0);
        check_value("rst_m0_rdata", m0_if.rdata, 0);
        check_value("rst_m1_rdata", m1_if.rdata, 0);
        resetn = 1'b1;

        // ---- single m0 write, slave ready after two BUSY cycles ----
        tick();
        m0_if.valid = 1'b1; m0_if.addr = 32'h0300_0000;
        m0_if.wdata = 32'h0000_000F; m0_if.wstrb = 4'hF;
        #2;
        check_value("wr_idle_s_valid", s_if.valid, 0);
        tick();
        #2;
        check_value("wr_s_valid", s_if.valid, 1);
        check_value("wr_s_addr",  s_if.addr,  32'h0300_0000);
        check_value("wr_s_wdata", s_if.wdata, 32'h0000_000F);
        check_value("wr_s_wstrb", s_if.wstrb, 4'hF);
        check_value("wr_grant",   grant_id,   0);
        check_value("wr_m0_ready_early", m0_if.ready, 0);
        tick();
        #2;
        check_value("wr_m0_ready_wait", m0_if.ready, 0);
        tick();
        s_if.ready = 1'b1;
        #2;
        check_value("wr_m0_ready", m0_if.ready, 1);
        check_value("wr_m1_ready", m1_if.ready, 0);
        tick();
        s_if.ready = 1'b0; m0_if.valid = 1'b0;
        #2;
        check_value("wr_done_m0_ready", m0_if.ready, 0);
        check_value("wr_done_s_valid",  s_if.valid,  0);
        tick();

        // ---- both masters from reset: strict alternation m0, m1, ... ----
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        m0_if.valid = 1'b1; m0_if.addr = 32'h0300_0010; m0_if.wstrb = 4'h0;
        m1_if.valid = 1'b1; m1_if.addr = 32'h0300_0020; m1_if.wstrb = 4'h0;
        served0 = 0;
        served1 = 0;
        exp_g   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wait_svalid(8, n);
            check_value("rr_latency", n, (i == 0) ? 1 : 3);
            check_value("rr_grant",   grant_id, exp_g);
            check_value("rr_s_addr",  s_if.addr, exp_g ? 32'h0300_0020 : 32'h0300_0010);
            s_if.rdata = 32'h1000_0000 + i;
            s_if.ready = 1'b1;
            #1;
            check_value("rr_gnt_ready",   exp_g ? m1_if.ready : m0_if.ready, 1);
            check_value("rr_other_ready", exp_g ? m0_if.ready : m1_if.ready, 0);
            check_value("rr_rdata", exp_g ? m1_if.rdata : m0_if.rdata, 32'h1000_0000 + i);
            served0 += int'(m0_if.ready);
            served1 += int'(m1_if.ready);
            exp_g = ~exp_g;
        end
        check_value("rr_served_m0", served0, 10);
        check_value("rr_served_m1", served1, 10);
        tick();
        s_if.ready = 1'b0; m0_if.valid = 1'b0; m1_if.valid = 1'b0;
        tick();

        // ---- m1 read: rdata only in the ready cycle ----
        m1_if.valid = 1'b1; m1_if.addr = 32'h0300_0000; m1_if.wstrb = 4'h0;
        s_if.rdata  = 32'hA5A5_A5A5;
        #2;
        check_value("rd_idle_m1_rdata", m1_if.rdata, 0);
        tick();
        #2;
        check_value("rd_grant",     grant_id,    1);
        check_value("rd_s_wstrb",   s_if.wstrb,  0);
        check_value("rd_s_addr",    s_if.addr,   32'h0300_0000);
        check_value("rd_busy_rdata", m1_if.rdata, 0);
        tick();
        s_if.ready = 1'b1;
        #2;
        check_value("rd_m1_ready", m1_if.ready, 1);
        check_value("rd_m1_rdata", m1_if.rdata, 32'hA5A5_A5A5);
        check_value("rd_m0_ready", m0_if.ready, 0);
        check_value("rd_m0_rdata", m0_if.rdata, 0);
        tick();
        s_if.ready = 1'b0; m1_if.valid = 1'b0;
        #2;
        check_value("rd_done_m1_rdata", m1_if.rdata, 0);
        check_value("rd_done_m1_ready", m1_if.ready, 0);
        tick();

        // ---- stray s_ready in IDLE is ignored ----
        s_if.ready = 1'b1; s_if.rdata = 32'h1234_5678;
        #2;
        check_value("stray_m0_ready", m0_if.ready, 0);
        check_value("stray_m1_ready", m1_if.ready, 0);
        check_value("stray_s_valid",  s_if.valid,  0);
        check_value("stray_m1_rdata", m1_if.rdata, 0);
        tick();
        s_if.ready = 1'b0;
        m0_if.valid = 1'b1; m0_if.addr = 32'h0300_0004; m0_if.wstrb = 4'hF;
        #2;
        check_value("stray_still_idle", s_if.valid, 0);
        tick();
        #2;
        check_value("stray_next_s_valid", s_if.valid, 1);
        check_value("stray_next_grant",   grant_id,   0);

        // ---- reset asserted while BUSY ----
        resetn = 1'b0; s_if.ready = 1'b1;
        #2;
        check_value("rstbusy_m0_ready", m0_if.ready, 0);
        tick();
        resetn = 1'b1; s_if.ready = 1'b0;
        m1_if.valid = 1'b1; m1_if.addr = 32'h0300_0008; m1_if.wstrb = 4'h0;
        #2;
        check_value("rstbusy_s_valid",  s_if.valid,  0);
        check_value("rstbusy_m0_idle",  m0_if.ready, 0);
        check_value("rstbusy_m1_idle",  m1_if.ready, 0);
        check_value("rstbusy_grant",    grant_id,    0);
        tick();
        #2;
        check_value("rstbusy_prio_grant", grant_id,  0);
        check_value("rstbusy_prio_valid", s_if.valid, 1);
        check_value("rstbusy_prio_addr",  s_if.addr,  32'h0300_0004);
        s_if.ready = 1'b1;
        #1;
        check_value("rstbusy_m0_done", m0_if.ready, 1);
        tick();
        s_if.ready = 1'b0; m0_if.valid = 1'b0;
        tick();
        tick();
        #2;
        check_value("rstbusy_m1_grant", grant_id,  1);
        check_value("rstbusy_m1_addr",  s_if.addr, 32'h0300_0008);
        s_if.ready = 1'b1; s_if.rdata = 32'h0000_0055;
        #1;
        check_value("rstbusy_m1_ready", m1_if.ready, 1);
        check_value("rstbusy_m1_rdata", m1_if.rdata, 32'h0000_0055);
        tick();
        s_if.ready = 1'b0; m1_if.valid = 1'b0;
        tick();

        // ---- master withdraws its request while BUSY ----
        m0_if.valid = 1'b1; m0_if.addr = 32'h0300_000C;
        tick();
        #2;
        check_value("abort_s_valid", s_if.valid, 1);
        m0_if.valid = 1'b0; m1_if.valid = 1'b1;
        #1;
        check_value("abort_drop_s_valid", s_if.valid,  0);
        check_value("abort_m0_ready",     m0_if.ready, 0);
        tick();
        #2;
        check_value("abort_idle_s_valid", s_if.valid,  0);
        check_value("abort_idle_m1_ready", m1_if.ready, 0);
        tick();
        #2;
        check_value("abort_m1_grant", grant_id,   1);
        check_value("abort_m1_valid", s_if.valid, 1);
        s_if.ready = 1'b1;
        #1;
        check_value("abort_m1_ready", m1_if.ready, 1);
        tick();
        s_if.ready = 1'b0; m1_if.valid = 1'b0;
        tick();

        // ---- watchdog ----
        m0_if.valid = 1'b1; m0_if.addr = 32'h0F00_0000; m0_if.wstrb = 4'h0;
        s_if.rdata  = 32'h0;
`ifdef IOMEM_ARB_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            tick();
            #2;
            if (k < 8) begin
                check_value("tmo_wait_ready", m0_if.ready, 0);
                check_value("tmo_wait_err",   timeout_err, 0);
            end else begin
                check_value("tmo_m0_ready", m0_if.ready, 1);
                check_value("tmo_m0_rdata", m0_if.rdata, 32'hDEAD_BEEF);
                check_value("tmo_err",      timeout_err, 1);
            end
        end
        tick();
        m0_if.valid = 1'b0;
        #2;
        check_value("tmo_done_err",     timeout_err, 0);
        check_value("tmo_done_s_valid", s_if.valid,  0);
        check_value("tmo_done_ready",   m0_if.ready, 0);
        tick();
        m1_if.valid = 1'b1; m1_if.addr = 32'h0300_0000; m1_if.wstrb = 4'h0;
        tick();
        #2;
        check_value("tmo_next_grant", grant_id, 1);
        s_if.ready = 1'b1; s_if.rdata = 32'h0BAD_F00D;
        #1;
        check_value("tmo_next_ready", m1_if.ready, 1);
        check_value("tmo_next_rdata", m1_if.rdata, 32'h0BAD_F00D);
        check_value("tmo_next_err",   timeout_err, 0);
        tick();
        s_if.ready = 1'b0; m1_if.valid = 1'b0;
        tick();
`else
        saw = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            #2;
            saw = saw | m0_if.ready | timeout_err;
        end
        check_value("notmo_no_ready_or_err", saw, 0);
        check_value("notmo_still_busy", s_if.valid, 1);
        s_if.ready = 1'b1; s_if.rdata = 32'h0BAD_F00D;
        #1;
        check_value("notmo_m0_ready", m0_if.ready, 1);
        check_value("notmo_m0_rdata", m0_if.rdata, 32'h0BAD_F00D);
        tick();
        s_if.ready = 1'b0; m0_if.valid = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_iomem_arbiter
`default_nettype wire

// File: doc/iomem_arbiter.md
Name: iomem_arbiter

Overview:
- Shares the single picosoc iomem peripheral bus (valid/ready/wstrb/addr/wdata/rdata) between two masters.
- m0 is the PicoRV32 iomem port; m1 is the host bridge (SPI/UART register access from LinuxCNC).
- Round-robin grant, one transaction at a time, with an optional bus-timeout watchdog so a missing slave cannot hang either master.
- Sits between the SoC/bridge and the address-decoded peripherals (GPIO at 0x03xx_xxxx etc.).

Parameters:
- ADDR_W, 32, address width for all ports.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- TIMEOUT_CYCLES, 255, BUSY cycles without s_ready before the transaction is aborted (with IOMEM_ARB_TIMEOUT_EN only); legal range 1..65535.
- TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned to the master on a timeout.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- m0_valid  in  1  master 0 request
- m0_ready  out  1  master 0 completion pulse
- m0_wstrb  in  DATA_W/8  master 0 byte strobes (0 = read)
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_rdata  out  DATA_W  master 0 read data, valid with m0_ready
- m1_valid, m1_ready, m1_wstrb, m1_addr, m1_wdata, m1_rdata  as m0, for master 1
- s_valid  out  1  request to slaves
- s_ready  in  1  slave completion
- s_wstrb  out  DATA_W/8  to slaves
- s_addr  out  ADDR_W  to slaves
- s_wdata  out  DATA_W  to slaves
- s_rdata  in  DATA_W  from slaves
- timeout_err  out  1  one-cycle pulse on a timeout abort
- grant_id  out  1  owner of the current/last grant (debug)

Behaviour:
- States: IDLE, BUSY, DONE. Reset: state=IDLE, rr_last=1 (so m0 wins the first tie), grant_id=0; all outputs 0: s_valid, m0_ready, m1_ready, timeout_err; m*_rdata=0.
- IDLE:
  - If exactly one mX_valid, grant X. If both, grant !rr_last.
  - Register grant_id and rr_last<=grant; go to BUSY.
  - No valid: stay in IDLE.
- BUSY:
  - s_valid = granted mX_valid; s_addr/s_wdata/s_wstrb combinationally muxed from the granted master.
  - The non-granted master sees ready=0.
  - Minimum latency: valid at cycle N in IDLE, s_valid at N+1.
- Completion (BUSY and s_ready=1):
  - mX_ready=1 for exactly that cycle; mX_rdata=s_rdata (combinational pass-through).
  - Go to DONE.
- DONE:
  - One turnaround cycle: s_valid=0, lets the master drop valid; go to IDLE.
  - A still-pending other master is granted on the following IDLE cycle.
  - Back-to-back throughput is one transaction per 3 cycles plus slave latency.
- Abort: granted mX_valid falls in BUSY without s_ready → go to IDLE, no ready pulse, rr_last keeps the grant.
- s_ready while not in BUSY: ignored, routed to no master.
- Reset asserted mid-transaction: return to IDLE the next edge; no ready is issued; the in-flight slave access is abandoned.
- Simultaneous new requests while BUSY: held off; they are arbitered only in IDLE.
- m*_rdata outside a ready cycle: 0.

Optional Feature:
- Macro IOMEM_ARB_TIMEOUT_EN.
- Defined:
  - 16-bit counter cleared on BUSY entry, increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES with s_ready=0: granted mX_ready=1, mX_rdata=TIMEOUT_RDATA, writes discarded, timeout_err=1 for one cycle, s_valid drops, go to DONE.
  - s_ready in the same cycle as the timeout wins: normal completion, no error.
- Undefined: no counter; BUSY waits indefinitely; timeout_err tied 0.

Decomposition:
- Package iomem_pkg: state enum (IDLE/BUSY/DONE), IOMEM_ADDR_W=32, IOMEM_DATA_W=32, IOMEM_TIMEOUT_RDATA=32'hDEAD_BEEF.
- One sub-module, iomem_arb_timeout: counter with clear/enable inputs and an expired output. Instantiated only under IOMEM_ARB_TIMEOUT_EN.

Test Plan:
- m0 write addr 0x0300_0000, wdata 0x0000_000F, wstrb 4'hF, slave ready after 2 cycles → s_valid at N+1, m0_ready one pulse, m1_ready=0, grant_id=0.
- m0 and m1 both valid from reset, slave ready after 1 cycle → m0 served first, then m1, alternating; neither starved over 10 back-to-back requests each.
- m1 read addr 0x0300_0000, slave s_rdata=0xA5A5_A5A5 → m1_rdata=0xA5A5_A5A5 exactly in the m1_ready cycle, 0 otherwise.
- With IOMEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: m0 read to an unmapped address, no s_ready → at BUSY cycle 8, m0_ready=1, m0_rdata=0xDEAD_BEEF, timeout_err pulse; next m1 request then served normally.
- resetn low for 1 cycle during BUSY → next cycle IDLE, s_valid=0, no mX_ready; later transactions complete normally with m0 priority.
- s_ready pulsed while IDLE → no mX_ready asserted, state unchanged.
